// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with occupancy count, programmable
// almost-full/almost-empty flags, a registered top-of-stack word, a pop-valid
// strobe, sticky overflow/underflow flags and a synchronous clear.
// Push and pop together replace the top entry, or pass the input word
// straight through when the stack is empty.
module param_stack #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       RstN,
    input  logic                       Clear,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic [DATA_W-1:0]          Data_In,
    output logic [DATA_W-1:0]          Data_Out,
    output logic                       Out_Valid,
    output logic [DATA_W-1:0]          Top,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Almost_Full,
    output logic                       Almost_Empty,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // One decoded operation per cycle; Clear outranks any request.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLEAR,
        OP_PUSH,
        OP_OVF,
        OP_POP,
        OP_UNF,
        OP_REPLACE,
        OP_PASS
    } op_e;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] top_q, top_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              full_q, empty_q, af_q, ae_q;

    op_e               op;
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [AW-1:0]     cnt_lo;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     below_idx;

    // Entry indices derived from the occupancy. N-1 and N-2 are always below
    // DEPTH, so modulo-2^AW arithmetic on the low bits yields them exactly; the
    // guards keep an empty or single-entry stack from forming a stray address.
    assign cnt_lo    = AW'(count_q);
    assign top_idx   = (count_q != '0)   ? cnt_lo - AW'(1) : '0;
    assign below_idx = (count_q >= 2'd2) ? cnt_lo - AW'(2) : '0;

    // Decode the request against the current occupancy.
    always_comb begin
        op = OP_IDLE;
        if (Clear)
            op = OP_CLEAR;
        else if (Push && Pop)
            op = (count_q == '0) ? OP_PASS : OP_REPLACE;
        else if (Push)
            op = (count_q == DEPTH_C) ? OP_OVF : OP_PUSH;
        else if (Pop)
            op = (count_q == '0) ? OP_UNF : OP_POP;
    end

    // Next-state values for the stack registers and the memory write port.
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;
        mem_wa  = cnt_lo;
        case (op)
            OP_CLEAR: begin
                count_d = '0;
                top_d   = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            OP_PUSH: begin
                mem_we  = 1'b1;
                mem_wa  = cnt_lo;
                count_d = count_q + ONE_C;
                top_d   = Data_In;
            end
            OP_OVF: ovf_d = 1'b1;
            OP_POP: begin
                dout_d  = mem[top_idx];
                valid_d = 1'b1;
                count_d = count_q - ONE_C;
                top_d   = (count_q == ONE_C) ? '0 : mem[below_idx];
            end
            OP_UNF: unf_d = 1'b1;
            OP_REPLACE: begin
                dout_d  = mem[top_idx];
                valid_d = 1'b1;
                mem_we  = 1'b1;
                mem_wa  = top_idx;
                top_d   = Data_In;
            end
            OP_PASS: begin
                dout_d  = Data_In;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage array; writes are suppressed while reset is asserted.
    // NOTE: the memory has no reset -- contents are only meaningful below
    // Count, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we && RstN)
            mem[mem_wa] <= Data_In;
    end

    // Stack state and flags, all registered from the next occupancy.
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            count_q <= '0;
            top_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_C == '0);
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= AF_C);
            ae_q    <= (count_d <= AE_C);
        end
    end

    assign Data_Out     = dout_q;
    assign Out_Valid    = valid_q;
    assign Top          = top_q;
    assign Count        = count_q;
    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_Full  = af_q;
    assign Almost_Empty = ae_q;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: drives a default 8-deep stack and a 5-deep stack
// (AF_LEVEL=4, AE_LEVEL=2) with shared stimulus and compares both against a
// behavioural LIFO model after every clock edge.
module tb_param_stack;

    logic       clk   = 1'b0;
    logic       RstN  = 1'b0;
    logic       Clear = 1'b0;
    logic       Push  = 1'b0;
    logic       Pop   = 1'b0;
    logic [7:0] Data_In = 8'h00;

    logic [7:0] d0_dout, d0_top;
    logic [3:0] d0_cnt;
    logic       d0_vld, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
    logic [7:0] d1_dout, d1_top;
    logic [2:0] d1_cnt;
    logic       d1_vld, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: array + occupancy per instance.
    logic [7:0] m_mem [2][8];
    int         m_cnt [2];
    logic [7:0] m_dout[2];
    bit         m_vld [2];
    bit         m_ovf [2];
    bit         m_unf [2];

    param_stack u_dut0 (
        .clk(clk), .RstN(RstN), .Clear(Clear), .Push(Push), .Pop(Pop),
        .Data_In(Data_In), .Data_Out(d0_dout), .Out_Valid(d0_vld), .Top(d0_top),
        .Count(d0_cnt), .Full(d0_full), .Empty(d0_empty), .Almost_Full(d0_af),
        .Almost_Empty(d0_ae), .Overflow(d0_ovf), .Underflow(d0_unf)
    );

    param_stack #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2)) u_dut1 (
        .clk(clk), .RstN(RstN), .Clear(Clear), .Push(Push), .Pop(Pop),
        .Data_In(Data_In), .Data_Out(d1_dout), .Out_Valid(d1_vld), .Top(d1_top),
        .Count(d1_cnt), .Full(d1_full), .Empty(d1_empty), .Almost_Full(d1_af),
        .Almost_Empty(d1_ae), .Overflow(d1_ovf), .Underflow(d1_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int depth_of(int i); return (i == 0) ? 8 : 5; endfunction
    function automatic int af_of(int i);    return (i == 0) ? 7 : 4; endfunction
    function automatic int ae_of(int i);    return (i == 0) ? 1 : 2; endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_dout[i] = 8'h00; m_vld[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end
    endtask

    task automatic model_step(bit psh, bit pp, bit clr, logic [7:0] din);
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_vld[i] = 0;
            end else if (psh && pp) begin
                if (m_cnt[i] == 0) begin
                    m_dout[i] = din;
                end else begin
                    m_dout[i] = m_mem[i][m_cnt[i]-1];
                    m_mem[i][m_cnt[i]-1] = din;
                end
                m_vld[i] = 1;
            end else if (psh) begin
                if (m_cnt[i] == depth_of(i)) m_ovf[i] = 1;
                else begin m_mem[i][m_cnt[i]] = din; m_cnt[i]++; end
                m_vld[i] = 0;
            end else if (pp) begin
                if (m_cnt[i] == 0) begin
                    m_unf[i] = 1; m_vld[i] = 0;
                end else begin
                    m_dout[i] = m_mem[i][m_cnt[i]-1]; m_cnt[i]--; m_vld[i] = 1;
                end
            end else begin
                m_vld[i] = 0;
            end
        end
    endtask

    task automatic check_dut(int i, string step);
        logic [31:0] o_dout, o_top, o_cnt, o_vld, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
        logic [31:0] e_top;
        string p;
        if (i == 0) begin
            o_dout = 32'(d0_dout); o_top = 32'(d0_top); o_cnt = 32'(d0_cnt); o_vld = 32'(d0_vld);
            o_full = 32'(d0_full); o_empty = 32'(d0_empty); o_af = 32'(d0_af); o_ae = 32'(d0_ae);
            o_ovf = 32'(d0_ovf); o_unf = 32'(d0_unf);
        end else begin
            o_dout = 32'(d1_dout); o_top = 32'(d1_top); o_cnt = 32'(d1_cnt); o_vld = 32'(d1_vld);
            o_full = 32'(d1_full); o_empty = 32'(d1_empty); o_af = 32'(d1_af); o_ae = 32'(d1_ae);
            o_ovf = 32'(d1_ovf); o_unf = 32'(d1_unf);
        end
        e_top = (m_cnt[i] == 0) ? 32'h0 : 32'(m_mem[i][m_cnt[i]-1]);
        p = $sformatf("%s d%0d", step, i);
        chk({p, " Data_Out"},     o_dout,  32'(m_dout[i]));
        chk({p, " Out_Valid"},    o_vld,   32'(m_vld[i]));
        chk({p, " Top"},          o_top,   e_top);
        chk({p, " Count"},        o_cnt,   32'(m_cnt[i]));
        chk({p, " Full"},         o_full,  32'(m_cnt[i] == depth_of(i)));
        chk({p, " Empty"},        o_empty, 32'(m_cnt[i] == 0));
        chk({p, " Almost_Full"},  o_af,    32'(m_cnt[i] >= af_of(i)));
        chk({p, " Almost_Empty"}, o_ae,    32'(m_cnt[i] <= ae_of(i)));
        chk({p, " Overflow"},     o_ovf,   32'(m_ovf[i]));
        chk({p, " Underflow"},    o_unf,   32'(m_unf[i]));
    endtask

    task automatic cyc(bit psh, bit pp, bit clr, logic [7:0] din, string step);
        @(negedge clk);
        Push = psh; Pop = pp; Clear = clr; Data_In = din;
        @(posedge clk);
        #1;
        model_step(psh, pp, clr, din);
        check_dut(0, step);
        check_dut(1, step);
    endtask

    initial begin
        model_reset();
        #12 RstN = 1'b1;
        check_dut(0, "reset");
        check_dut(1, "reset");
        chk("reset Empty const", 32'(d0_empty), 32'h1);

        // Fill to three, then pull reset between clock edges.
        cyc(1, 0, 0, 8'h11, "pre-rst push");
        cyc(1, 0, 0, 8'h22, "pre-rst push");
        cyc(1, 0, 0, 8'h33, "pre-rst push");
        @(negedge clk);
        Push = 0; Pop = 0; Clear = 0;
        #2 RstN = 1'b0;
        #1;
        model_reset();
        chk("async rst Count", 32'(d0_cnt), 32'h0);
        chk("async rst Top", 32'(d0_top), 32'h0);
        chk("async rst Empty", 32'(d0_empty), 32'h1);
        chk("async rst AE", 32'(d0_ae), 32'h1);
        check_dut(0, "async rst");
        check_dut(1, "async rst");
        @(negedge clk);
        RstN = 1'b1;

        cyc(1, 0, 0, 8'h11, "push");
        cyc(1, 0, 0, 8'h22, "push");
        cyc(1, 0, 0, 8'h33, "push");
        chk("basic Count", 32'(d0_cnt), 32'd3);
        chk("basic Top", 32'(d0_top), 32'h33);

        // Clear beats a simultaneous push.
        cyc(1, 0, 1, 8'h77, "clear+push");
        chk("clear prio Count", 32'(d0_cnt), 32'd0);
        chk("clear prio Out_Valid", 32'(d0_vld), 32'd0);

        // Fill both (5-deep one overflows), then overflow the 8-deep one.
        for (int k = 1; k <= 8; k++) cyc(1, 0, 0, 8'(k), "fill");
        chk("fill Full", 32'(d0_full), 32'h1);
        cyc(1, 0, 0, 8'hAA, "ovf push");
        chk("ovf Overflow", 32'(d0_ovf), 32'h1);
        chk("ovf Top", 32'(d0_top), 32'h08);

        for (int k = 8; k >= 1; k--) begin
            cyc(0, 1, 0, 8'h00, "drain");
            chk("drain Data_Out", 32'(d0_dout), 32'(k));
        end
        cyc(0, 1, 0, 8'h00, "unf pop");
        chk("unf Data_Out holds", 32'(d0_dout), 32'h01);
        chk("unf Underflow", 32'(d0_unf), 32'h1);
        cyc(0, 0, 1, 8'h00, "clear flags");

        // Replace top, then pass-through on an empty stack.
        cyc(1, 0, 0, 8'h10, "push");
        cyc(1, 0, 0, 8'h20, "push");
        cyc(1, 1, 0, 8'h99, "replace");
        chk("replace Data_Out", 32'(d0_dout), 32'h20);
        chk("replace Top", 32'(d0_top), 32'h99);
        cyc(0, 0, 1, 8'h00, "clear");
        cyc(1, 1, 0, 8'h5A, "pass");
        chk("pass Data_Out", 32'(d0_dout), 32'h5A);
        cyc(0, 0, 0, 8'h00, "idle");

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit psh, pp, clr;
            psh = ($urandom_range(0, 99) < 55);
            pp  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 39) == 0);
            cyc(psh, pp, clr, 8'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack, next generation of the team's 8x8 push/pop stack.
- Generalised in data width and depth. Adds:
  - an occupancy count;
  - programmable almost-full and almost-empty flags;
  - a registered top-of-stack peek;
  - a pop-valid strobe;
  - sticky overflow/underflow error flags;
  - a synchronous clear;
  - defined push+pop behaviour for every occupancy, including empty.
- Sits between a producer/consumer pair, e.g. as an expression-evaluation or return-address stack in the datapath.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2, need not be a power of two).
- AF_LEVEL, DEPTH-1, Almost_Full asserts when Count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, Almost_Empty asserts when Count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- RstN  in  1  asynchronous active-low reset.
- Clear  in  1  synchronous flush: empties the stack and clears the error flags.
- Push  in  1  push request.
- Pop  in  1  pop request.
- Data_In  in  DATA_W  word to push.
- Data_Out  out  DATA_W  registered popped word.
- Out_Valid  out  1  one-cycle strobe: Data_Out was updated by a pop this cycle.
- Top  out  DATA_W  current top-of-stack word; 0 when empty.
- Count  out  CW  occupancy 0..DEPTH, where CW = $clog2(DEPTH+1).
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Almost_Full  out  1  Count >= AF_LEVEL.
- Almost_Empty  out  1  Count <= AE_LEVEL.
- Overflow  out  1  sticky: a push was rejected.
- Underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (RstN low, asynchronous, independent of clk):
  - Count=0, Data_Out=0, Out_Valid=0, Top=0, Overflow=0, Underflow=0.
  - Empty=1, Almost_Empty=1, Full=0, Almost_Full=(AF_LEVEL==0 ? 1 : 0).
  - Memory contents are not reset.
  - Reset mid-operation aborts any in-flight push/pop with no partial state.
- All state updates on the rising clk edge.
- All flags and Top are registered and consistent with Count after the same edge. No combinational path from inputs to outputs.
- Priority: RstN > Clear > Push/Pop.
- Clear: Count<=0, Overflow<=0, Underflow<=0, Top<=0, Out_Valid<=0. Data_Out holds its value; Push/Pop in the same cycle are ignored.
- Operations (N = Count before the edge):
  - Push only, N<DEPTH: Mem[N]<=Data_In; Count<=N+1; Top<=Data_In.
  - Push only, N==DEPTH: rejected, no state change except Overflow<=1.
  - Pop only, N>0: Data_Out<=Mem[N-1]; Out_Valid<=1; Count<=N-1; Top<=Mem[N-2], or 0 if N==1.
  - Pop only, N==0: rejected; Underflow<=1; Out_Valid<=0; Data_Out holds.
  - Push+Pop, N>0 (including N==DEPTH): replace top. Data_Out<=Mem[N-1]; Out_Valid<=1; Mem[N-1]<=Data_In; Top<=Data_In; Count unchanged; no error flag.
  - Push+Pop, N==0: pass-through. Data_Out<=Data_In; Out_Valid<=1; Count stays 0; no error flag.
  - Neither: hold all state; Out_Valid<=0.
- Out_Valid is high for exactly one cycle per accepted pop; back-to-back pops give a continuous high.
- Error flags are sticky until Clear or reset. A rejected request never corrupts Count, memory or Top.
- Count arithmetic is CW bits wide and never wraps: saturation is enforced by the full/empty rejection rules.
- Memory index width is $clog2(DEPTH). Non-power-of-two DEPTH must never address beyond DEPTH-1.
- Top is maintained as a register updated alongside memory, not a combinational read.

Test Plan:
- Reset/basic: RstN low mid-stream with Count=3 -> all outputs at reset values immediately, before the next clk edge. Release, push 0x11,0x22,0x33 -> Count=3, Top=0x33, Empty=0.
- Order: DATA_W=8, DEPTH=8; push 0x01..0x08 -> Full=1, Almost_Full=1 at Count=7. Then pop 8 times -> Data_Out=0x08..0x01 with Out_Valid high each cycle, Empty=1, Top=0.
- Overflow/underflow: on full stack push 0xAA -> Overflow=1, Count=8, Top unchanged. Pop to empty, pop again -> Underflow=1, Data_Out holds 0x01, Out_Valid=0. Clear -> both flags 0.
- Simultaneous: Count=2 (0x10,0x20), Push+Pop with 0x99 -> Data_Out=0x20, Top=0x99, Count=2. On empty stack, Push+Pop with 0x5A -> Data_Out=0x5A, Out_Valid=1, Count=0, no error.
- Non-power-of-two: DEPTH=5, AF_LEVEL=4, AE_LEVEL=2; push 6 words -> Full at Count=5, 6th sets Overflow, Almost_Full from Count=4, Almost_Empty true for Count<=2. Pop all -> LIFO order intact.
- Clear priority: Clear asserted together with Push at Count=3 -> Count=0, push ignored, Data_Out unchanged, Out_Valid=0.
